// File: rtl/interrupt_sequencer_if.sv
// Decoder-facing signal bundle of the interrupt sequencer.
// The slave side is the sequencer; the master side is the decoder and the pins.
interface interrupt_sequencer_if;
    logic        irqb;
    logic        nmib;
    logic        rdy;
    logic        sync;
    logic        brk_op;
    logic        i_flag;

    logic        seq_active;
    logic [2:0]  seq_step;
    logic [1:0]  seq_kind;
    logic        force_brk;
    logic        push_cycle;
    logic        write_inhibit;
    logic        vector_fetch;
    logic [15:0] vector_addr;
    logic        vpb;
    logic        b_flag_out;
    logic        set_i;
    logic        clear_d;
    logic        seq_done;

    modport slave (
        input  irqb, nmib, rdy, sync, brk_op, i_flag,
        output seq_active, seq_step, seq_kind, force_brk, push_cycle,
               write_inhibit, vector_fetch, vector_addr, vpb, b_flag_out,
               set_i, clear_d, seq_done
    );

    modport master (
        output irqb, nmib, rdy, sync, brk_op, i_flag,
        input  seq_active, seq_step, seq_kind, force_brk, push_cycle,
               write_inhibit, vector_fetch, vector_addr, vpb, b_flag_out,
               set_i, clear_d, seq_done
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt/reset sequencer for the 65C02 core.
// Detects RST/NMI/IRQ/BRK, arbitrates at instruction boundaries and runs the
// 7-step entry sequence (dummy reads, stack pushes, vector fetch).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | normal execution, waiting for sync/brk_op to start entry
// S_SEQ  | entry sequence running, r_step 0..6, r_kind selects vector
module interrupt_sequencer #(
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] RST_VEC = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
    input  logic                  phi2,
    input  logic                  resb,
    interrupt_sequencer_if.slave  bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEQ  = 1'b1
    } state_t;

    localparam logic [1:0] K_RST = 2'd0;
    localparam logic [1:0] K_NMI = 2'd1;
    localparam logic [1:0] K_IRQ = 2'd2;
    localparam logic [1:0] K_BRK = 2'd3;

    state_t      r_state;
    state_t      w_state_nx;
    logic [2:0]  r_step;
    logic [2:0]  w_step_nx;
    logic [1:0]  r_kind;
    logic [1:0]  w_kind_nx;
    logic        r_nmi_prev;
    logic        r_nmi_pend;

    logic        w_active;
    logic        w_nmi_fall;
    logic        w_nmi_clr;
    logic        w_irq_req;
    logic [15:0] w_base;

    assign w_active   = (r_state == S_SEQ);
    assign w_nmi_fall = ~bus.nmib & r_nmi_prev;
    // The NMI is consumed once its own sequence reaches the vector fetch.
    assign w_nmi_clr  = w_active & bus.rdy & (r_kind == K_NMI) & (r_step == 3'd5);
    assign w_irq_req  = ~bus.irqb & ~bus.i_flag;

    // State register; the NMI edge detector keeps running while rdy is low.
    always_ff @(posedge phi2 or negedge resb) begin
        if (!resb) begin
            r_state    <= S_SEQ;
            r_step     <= 3'd0;
            r_kind     <= K_RST;
            r_nmi_prev <= 1'b1;
            r_nmi_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_step     <= w_step_nx;
            r_kind     <= w_kind_nx;
            r_nmi_prev <= bus.nmib;
            // A fresh falling edge in the clearing cycle keeps the request.
            r_nmi_pend <= w_nmi_fall | (r_nmi_pend & ~w_nmi_clr);
        end
    end

    // Next state: boundary arbitration, step advance and NMI vector hijack.
    always_comb begin
        w_state_nx = r_state;
        w_step_nx  = r_step;
        w_kind_nx  = r_kind;
        if (bus.rdy) begin
            if (r_state == S_IDLE) begin
                if (bus.sync && r_nmi_pend) begin
                    w_state_nx = S_SEQ;
                    w_kind_nx  = K_NMI;
                    w_step_nx  = 3'd0;
                end else if (bus.sync && w_irq_req) begin
                    w_state_nx = S_SEQ;
                    w_kind_nx  = K_IRQ;
                    w_step_nx  = 3'd0;
                end else if (bus.brk_op) begin
                    // BRK opcode already fetched, so its sequence begins at step 1.
                    w_state_nx = S_SEQ;
                    w_kind_nx  = K_BRK;
                    w_step_nx  = 3'd1;
                end
            end else begin
                // Late NMI steals the vector of an IRQ/BRK still before its fetch.
                if (((r_kind == K_IRQ) || (r_kind == K_BRK)) && r_nmi_pend &&
                    (r_step <= 3'd4)) begin
                    w_kind_nx = K_NMI;
                end
                if (r_step == 3'd6) begin
                    w_state_nx = S_IDLE;
                    w_step_nx  = 3'd0;
                end else begin
                    w_step_nx  = r_step + 3'd1;
                end
            end
        end
    end

    // Vector base selection from the sequence kind.
    always_comb begin
        w_base = IRQ_VEC;
        case (r_kind)
            K_RST:   w_base = RST_VEC;
            K_NMI:   w_base = NMI_VEC;
            K_IRQ:   w_base = IRQ_VEC;
            K_BRK:   w_base = IRQ_VEC;
            default: w_base = IRQ_VEC;
        endcase
    end

    // Decoder-facing outputs decoded from state, step and kind.
    always_comb begin
        bus.seq_active    = w_active;
        bus.seq_step      = r_step;
        bus.seq_kind      = r_kind;
        bus.force_brk     = w_active && (r_step <= 3'd1) && (r_kind != K_BRK);
        bus.push_cycle    = w_active && (r_step >= 3'd2) && (r_step <= 3'd4) &&
                            (r_kind != K_RST);
        bus.write_inhibit = w_active && (r_step >= 3'd2) && (r_step <= 3'd4) &&
                            (r_kind == K_RST);
        bus.vector_fetch  = w_active && (r_step >= 3'd5);
        bus.vpb           = ~(w_active && (r_step >= 3'd5));
        bus.vector_addr   = w_base | {15'b0, (r_step == 3'd6)};
        bus.b_flag_out    = (r_kind == K_BRK);
        bus.set_i         = w_active && (r_step == 3'd6) && bus.rdy;
        bus.clear_d       = w_active && (r_step == 3'd6) && bus.rdy;
        bus.seq_done      = w_active && (r_step == 3'd6) && bus.rdy;
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: an event-level model of the
// entry sequence is checked against the DUT every cycle, and directed scenarios
// pin the model with literal step/vector expectations.
module tb_interrupt_sequencer;

    logic phi2;
    logic resb;
    interrupt_sequencer_if ifc ();

    interrupt_sequencer dut (
        .phi2 (phi2),
        .resb (resb),
        .bus  (ifc)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    initial begin
        phi2 = 1'b0;
        forever #5 phi2 = ~phi2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: "is a sequence running, which kind, which cycle", plus the NMI latch.
    bit          m_active;
    int          m_kind;
    int          m_step;
    bit          m_prev;
    bit          m_pend;
    bit          m_fall;
    bit          m_clr;
    logic [15:0] m_vec;

    always @(posedge phi2 or negedge resb) begin
        if (!resb) begin
            m_active = 1'b1;
            m_kind   = 0;
            m_step   = 0;
            m_prev   = 1'b1;
            m_pend   = 1'b0;
        end else begin
            m_fall = !ifc.nmib && m_prev;
            m_clr  = 1'b0;
            if (ifc.rdy) begin
                if (m_active) begin
                    if ((m_kind == 2 || m_kind == 3) && m_pend && m_step <= 4) m_kind = 1;
                    if (m_kind == 1 && m_step == 5) m_clr = 1'b1;
                    if (m_step == 6) begin
                        m_active = 1'b0;
                        m_step   = 0;
                    end else begin
                        m_step = m_step + 1;
                    end
                end else if (ifc.sync && m_pend) begin
                    m_active = 1'b1; m_kind = 1; m_step = 0;
                end else if (ifc.sync && !ifc.irqb && !ifc.i_flag) begin
                    m_active = 1'b1; m_kind = 2; m_step = 0;
                end else if (ifc.brk_op) begin
                    m_active = 1'b1; m_kind = 3; m_step = 1;
                end
            end
            m_pend = m_fall || (m_pend && !m_clr);
            m_prev = ifc.nmib;
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge phi2) begin
        chk("seq_active", ifc.seq_active, m_active);
        chk("seq_step", ifc.seq_step, m_step);
        chk("force_brk", ifc.force_brk, m_active && m_step <= 1 && m_kind != 3);
        chk("push_cycle", ifc.push_cycle, m_active && m_step >= 2 && m_step <= 4 && m_kind != 0);
        chk("write_inhibit", ifc.write_inhibit, m_active && m_step >= 2 && m_step <= 4 && m_kind == 0);
        chk("vector_fetch", ifc.vector_fetch, m_active && m_step >= 5);
        chk("vpb", ifc.vpb, !(m_active && m_step >= 5));
        chk("set_i", ifc.set_i, m_active && m_step == 6 && ifc.rdy);
        chk("clear_d", ifc.clear_d, m_active && m_step == 6 && ifc.rdy);
        chk("seq_done", ifc.seq_done, m_active && m_step == 6 && ifc.rdy);
        if (m_active) begin
            m_vec = (m_kind == 0) ? 16'hFFFC : (m_kind == 1) ? 16'hFFFA : 16'hFFFE;
            if (m_step == 6) m_vec = m_vec + 16'd1;
            chk("seq_kind", ifc.seq_kind, m_kind);
            chk("vector_addr", ifc.vector_addr, m_vec);
            chk("b_flag_out", ifc.b_flag_out, m_kind == 3);
        end
    end

    task automatic tick();
        @(posedge phi2);
        #2;
    endtask

    // Literal walk through a sequence from its first visible step to completion.
    task automatic check_seq(input int kind, input int first, input logic [15:0] base);
        for (int s = first; s <= 6; s++) begin
            chk("lit_step", ifc.seq_step, s);
            chk("lit_kind", ifc.seq_kind, kind);
            chk("lit_push", ifc.push_cycle, kind != 0 && s >= 2 && s <= 4);
            chk("lit_winh", ifc.write_inhibit, kind == 0 && s >= 2 && s <= 4);
            chk("lit_vpb", ifc.vpb, s < 5);
            chk("lit_bflag", ifc.b_flag_out, kind == 3);
            if (s >= 5) chk("lit_vec", ifc.vector_addr, base | {15'b0, s == 6});
            chk("lit_done", ifc.seq_done, s == 6);
            chk("lit_set_i", ifc.set_i, s == 6);
            tick();
        end
        chk("lit_idle", ifc.seq_active, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "timeout");
    end

    int n_wait;

    initial begin
        resb        = 1'b1;
        ifc.irqb    = 1'b1;
        ifc.nmib    = 1'b1;
        ifc.rdy     = 1'b1;
        ifc.sync    = 1'b0;
        ifc.brk_op  = 1'b0;
        ifc.i_flag  = 1'b1;
        #1 resb = 1'b0;
        tick();
        tick();

        // Held in reset
        chk("rst_active", ifc.seq_active, 1'b1);
        chk("rst_step", ifc.seq_step, 3'd0);
        chk("rst_kind", ifc.seq_kind, 2'd0);
        chk("rst_force_brk", ifc.force_brk, 1'b1);
        chk("rst_vec", ifc.vector_addr, 16'hFFFC);
        chk("rst_vpb", ifc.vpb, 1'b1);
        chk("rst_push", ifc.push_cycle, 1'b0);
        chk("rst_set_i", ifc.set_i, 1'b0);

        // Reset release: full RST sequence
        resb = 1'b1;
        check_seq(0, 0, 16'hFFFC);
        tick();

        // IRQ taken
        ifc.i_flag = 1'b0; ifc.irqb = 1'b0; ifc.sync = 1'b1;
        tick();
        ifc.sync = 1'b0; ifc.irqb = 1'b1;
        check_seq(2, 0, 16'hFFFE);

        // IRQ masked by I flag
        ifc.i_flag = 1'b1; ifc.irqb = 1'b0; ifc.sync = 1'b1;
        tick();
        chk("irq_masked", ifc.seq_active, 1'b0);
        ifc.sync = 1'b0; ifc.irqb = 1'b1;
        tick();

        // NMI beats IRQ at the same boundary; held-low nmib does not retrigger
        ifc.nmib = 1'b0; ifc.irqb = 1'b0; ifc.i_flag = 1'b0;
        tick();
        ifc.sync = 1'b1;
        tick();
        ifc.sync = 1'b0; ifc.irqb = 1'b1;
        check_seq(1, 0, 16'hFFFA);
        ifc.sync = 1'b1;
        tick();
        chk("nmi_no_retrigger", ifc.seq_active, 1'b0);
        ifc.sync = 1'b0; ifc.nmib = 1'b1;
        tick();

        // BRK starts at step 1
        ifc.brk_op = 1'b1;
        tick();
        ifc.brk_op = 1'b0;
        chk("brk_force", ifc.force_brk, 1'b0);
        check_seq(3, 1, 16'hFFFE);
        tick();

        // BRK hijacked by an NMI edge at step 3
        ifc.brk_op = 1'b1;
        tick();
        ifc.brk_op = 1'b0;
        tick();
        tick();
        chk("hj_step3", ifc.seq_step, 3'd3);
        ifc.nmib = 1'b0;
        tick();
        chk("hj_step4_kind", ifc.seq_kind, 2'd3);
        chk("hj_step4_bflag", ifc.b_flag_out, 1'b1);
        chk("hj_step4_push", ifc.push_cycle, 1'b1);
        tick();
        chk("hj_step5_kind", ifc.seq_kind, 2'd1);
        chk("hj_step5_vec", ifc.vector_addr, 16'hFFFA);
        tick();
        chk("hj_step6_vec", ifc.vector_addr, 16'hFFFB);
        chk("hj_done", ifc.seq_done, 1'b1);
        ifc.nmib = 1'b1;
        tick();
        chk("hj_idle", ifc.seq_active, 1'b0);
        ifc.sync = 1'b1;
        tick();
        chk("hj_pend_cleared", ifc.seq_active, 1'b0);
        ifc.sync = 1'b0;
        tick();

        // rdy stall at step 4 for 3 cycles, then at step 6
        ifc.i_flag = 1'b0; ifc.irqb = 1'b0; ifc.sync = 1'b1;
        tick();
        ifc.sync = 1'b0; ifc.irqb = 1'b1;
        repeat (4) tick();
        chk("stall_at4", ifc.seq_step, 3'd4);
        ifc.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", ifc.seq_step, 3'd4);
            chk("stall_no_done", ifc.seq_done, 1'b0);
        end
        ifc.rdy = 1'b1;
        n_wait = 0;
        while (ifc.seq_done !== 1'b1 && n_wait < 20) begin
            tick();
            n_wait++;
        end
        chk("stall_total_edges", 4 + 3 + n_wait, 9);
        ifc.rdy = 1'b0;
        #1;
        chk("stall6_no_done", ifc.seq_done, 1'b0);
        chk("stall6_no_set_i", ifc.set_i, 1'b0);
        tick();
        chk("stall6_hold", ifc.seq_step, 3'd6);
        ifc.rdy = 1'b1;
        #1;
        chk("stall6_done", ifc.seq_done, 1'b1);
        tick();
        chk("stall_idle", ifc.seq_active, 1'b0);
        ifc.i_flag = 1'b1;
        tick();

        // Reset asserted during IRQ step 5
        ifc.i_flag = 1'b0; ifc.irqb = 1'b0; ifc.sync = 1'b1;
        tick();
        ifc.sync = 1'b0; ifc.irqb = 1'b1; ifc.i_flag = 1'b1;
        repeat (5) tick();
        chk("mid_step5", ifc.seq_step, 3'd5);
        chk("mid_kind", ifc.seq_kind, 2'd2);
        resb = 1'b0;
        #1;
        chk("mid_rst_step", ifc.seq_step, 3'd0);
        chk("mid_rst_kind", ifc.seq_kind, 2'd0);
        chk("mid_rst_vec", ifc.vector_addr, 16'hFFFC);
        chk("mid_rst_active", ifc.seq_active, 1'b1);
        tick();
        resb = 1'b1;
        check_seq(0, 0, 16'hFFFC);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
Upstream companion to the instruction decoder in the 65C02 core. It detects and prioritises reset, NMI, IRQ and BRK. It arbitrates them at instruction boundaries (sync) and runs the 7-cycle interrupt/reset sequence. During that sequence it tells the decoder which cycle is a dummy read, a stack push or a vector fetch, and it supplies the vector address, the VPB pin and the status side-effects.

Parameters:
NMI_VEC, 16'hFFFA, NMI vector base
RST_VEC, 16'hFFFC, reset vector base
IRQ_VEC, 16'hFFFE, IRQ/BRK vector base

Ports:
phi2  in  1  core clock; all state updates on rising edge
resb  in  1  asynchronous active-low reset
irqb  in  1  IRQ pin, level-sensitive, active-low
nmib  in  1  NMI pin, falling-edge-sensitive
rdy  in  1  1 = advance; 0 = freeze all sequencing state
sync  in  1  decoder opcode-fetch cycle (instruction boundary)
brk_op  in  1  decoder has BRK (00) in the instruction register, one-cycle pulse
i_flag  in  1  processor status I bit
seq_active  out  1  sequence in progress
seq_step  out  3  current step 0..6
seq_kind  out  2  0=RST 1=NMI 2=IRQ 3=BRK
force_brk  out  1  decoder must substitute opcode 00 for the fetched byte
push_cycle  out  1  steps 2..4 of an NMI/IRQ/BRK sequence (stack write)
write_inhibit  out  1  steps 2..4 of a RST sequence (read, SP still decrements)
vector_fetch  out  1  steps 5..6
vector_addr  out  16  vector address; bit0 = (seq_step==6)
vpb  out  1  low during steps 5..6, else high
b_flag_out  out  1  B bit to push at step 4: 1 only for BRK
set_i  out  1  one-cycle pulse at step 6
clear_d  out  1  one-cycle pulse at step 6
seq_done  out  1  one-cycle pulse at step 6

Behaviour:
- States: IDLE, SEQ. Registers: step[2:0], kind[1:0], nmi_prev, nmi_pend.
- Async reset (resb=0): state=SEQ, kind=RST, step=0, nmi_prev=1, nmi_pend=0.
  - Outputs held at reset: seq_active=1, seq_step=0, seq_kind=0, force_brk=1, vector_addr=RST_VEC, vpb=1. All other outputs 0.
  - Sequence runs from the first rising phi2 after resb releases.
- NMI detect, every edge regardless of rdy:
  - nmi_prev<=nmib.
  - nmib==0 && nmi_prev==1 sets nmi_pend.
  - nmi_pend clears at the step-5 edge of a sequence whose kind is NMI (rdy=1).
  - A new falling edge in the same cycle as the clear wins: nmi_pend stays 1.
- irq_req = ~irqb & ~i_flag, combinational; not latched.
- IDLE, rdy=1, start priority:
  - sync && nmi_pend: SEQ, kind=NMI, step=0.
  - else sync && irq_req: SEQ, kind=IRQ, step=0.
  - else brk_op: SEQ, kind=BRK, step=1. The opcode is already fetched, so step 0 is skipped.
- SEQ, rdy=1: step increments each edge. At step 6 the next edge goes to IDLE, step=0.
- rdy=0: state, step and kind hold. Outputs are stable but pulse outputs are qualified by rdy: set_i, clear_d and seq_done assert only when step==6 && rdy==1.
- force_brk = seq_active && step<=1 && kind!=BRK.
- push_cycle = seq_active && step in 2..4 && kind!=RST. write_inhibit is the same condition with kind==RST.
- Vector hijack: in an IRQ or BRK sequence, if nmi_pend==1 at any edge with step<=4, kind becomes NMI at that edge.
  - The vector fetch then uses NMI_VEC; b_flag_out is unchanged from BRK if already past step 4.
  - This is the only path by which kind changes mid-sequence.
- vector_addr = base(kind) | {15'b0, step==6}. Base is RST_VEC, NMI_VEC, or IRQ_VEC for IRQ and BRK. Value is don't-care outside steps 5..6 but must be deterministic: output base(kind).
- b_flag_out = (kind==BRK).
- resb asserted mid-sequence: immediate async restart as RST step 0. Any pending NMI is dropped.
- No interrupt is taken at an instruction boundary while seq_active=1. A pending IRQ is re-evaluated at the first sync after seq_done; set_i normally masks it.
- Latency: pin falling edge to nmi_pend is 1 edge; nmi_pend to seq_active requires the next sync with rdy=1.

Test Plan:
- Reset release: resb 0→1, rdy=1 → seq_step 0..6 over 7 edges.
  - write_inhibit=1 at steps 2..4, push_cycle never asserts.
  - vpb=0 at steps 5..6 with vector_addr FFFC then FFFD; set_i, clear_d and seq_done pulse once; then seq_active=0.
- IRQ: irqb=0, i_flag=0, sync pulse → kind=2, push_cycle steps 2..4, b_flag_out=0, vectors FFFE/FFFF. Same stimulus with i_flag=1 → no sequence.
- NMI edge with irqb=0 and i_flag=0 at the same sync → kind=1 wins, vectors FFFA/FFFB, nmi_pend cleared at step 5. A held-low nmib does not retrigger.
- BRK: brk_op pulse → starts at step 1, force_brk=0, b_flag_out=1, vectors FFFE/FFFF.
  - Variant: NMI falling edge while BRK is at step 3 → vector switches to FFFA/FFFB.
- rdy=0 for 3 cycles at step 4 → seq_step holds 4 and no pulses occur; after rdy=1, completion is 3 cycles later than the baseline.
- resb pulsed low during IRQ step 5 → outputs immediately show RST step 0 (vector_addr=FFFC, seq_kind=0), and a full reset sequence follows.
